dual_list_writer: RTL and testbench

//  Write-side companion of the two-list nested-loop reader. Captures two independent input

---
 rtl/dual_list_writer_pkg.sv | 15 +
 rtl/list_write_ctr.sv | 62 ++++++
 rtl/dual_list_writer.sv | 117 +++++++++++
 tb/tb_dual_list_writer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dual_list_writer_pkg.sv
// Shared definitions for the two-list ping-pong writer.
// Default widths, FSM encoding and the list-count type.
package dual_list_writer_pkg;

   localparam int DEF_DATA_W = 36;
   localparam int DEF_ADDR_W = 6;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   typedef logic [DEF_ADDR_W-1:0] list_cnt_t;

endpackage

// File: rtl/list_write_ctr.sv
// Per-list write port: registers each accepted beat, counts entries,
// saturates at a full page and flags dropped beats until the next event.
module list_write_ctr
   import dual_list_writer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              clear,
   input  logic              page,
   input  logic              valid,
   input  logic [DATA_W-1:0] din,
   output logic              wr_en,
   output logic [ADDR_W:0]   wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] cnt,
   output logic              ovf
);

   localparam logic [ADDR_W-1:0] FULL = '1;

   logic              full;
   logic              take;
   logic              drop;
   logic [ADDR_W-1:0] idx;

   // A beat riding with the event strobe opens the new event at index 0.
   assign full = (cnt == FULL);
   assign take = valid & (clear | (en & ~full));
   assign drop = valid & en & ~clear & full;
   assign idx  = clear ? '0 : cnt;

   // Write register, entry counter and sticky drop flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
      end else begin
         wr_en <= take;
         if (take) begin
            wr_addr <= {page, idx};
            wr_data <= din;
         end
         if (clear) begin
            cnt <= take ? ADDR_W'(1) : '0;
            ovf <= 1'b0;
         end else begin
            if (take)
               cnt <= cnt + ADDR_W'(1);
            if (drop)
               ovf <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dual_list_writer.sv
// Two-list ping-pong writer: captures both streams per event and
// publishes per-list counts plus the completed page on each boundary.
module dual_list_writer
   import dual_list_writer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] din1,
   input  logic              valid1,
   input  logic [DATA_W-1:0] din2,
   input  logic              valid2,
   output logic              wr_en1,
   output logic [ADDR_W:0]   wr_addr1,
   output logic [DATA_W-1:0] wr_data1,
   output logic              wr_en2,
   output logic [ADDR_W:0]   wr_addr2,
   output logic [DATA_W-1:0] wr_data2,
   output logic [ADDR_W-1:0] number1out,
   output logic [ADDR_W-1:0] number2out,
   output logic              rd_page,
   output logic              done,
   output logic [1:0]        overflow
);

   state_t            state;
   state_t            state_n;
   logic              publish;
   logic              page;
   logic              page_n;
   logic              filling;
   logic [ADDR_W-1:0] cnt1;
   logic [ADDR_W-1:0] cnt2;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next state and event-boundary decode; the page flips only when closing an event.
   always_comb begin
      state_n = state;
      publish = 1'b0;
      page_n  = page;
      filling = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_n = FILL;
         end
         FILL: begin
            filling = 1'b1;
            if (start) begin
               publish = 1'b1;
               page_n  = ~page;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Page register and publication of the completed event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         page       <= 1'b0;
         rd_page    <= 1'b1;
         number1out <= '0;
         number2out <= '0;
         done       <= 1'b0;
      end else begin
         done <= publish;
         page <= page_n;
         if (publish) begin
            rd_page    <= page;
            number1out <= cnt1;
            number2out <= cnt2;
         end
      end
   end

   list_write_ctr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_list1 (
      .clk     (clk),
      .reset   (reset),
      .en      (filling),
      .clear   (start),
      .page    (page_n),
      .valid   (valid1),
      .din     (din1),
      .wr_en   (wr_en1),
      .wr_addr (wr_addr1),
      .wr_data (wr_data1),
      .cnt     (cnt1),
      .ovf     (overflow[0])
   );

   list_write_ctr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_list2 (
      .clk     (clk),
      .reset   (reset),
      .en      (filling),
      .clear   (start),
      .page    (page_n),
      .valid   (valid2),
      .din     (din2),
      .wr_en   (wr_en2),
      .wr_addr (wr_addr2),
      .wr_data (wr_data2),
      .cnt     (cnt2),
      .ovf     (overflow[1])
   );

endmodule

// File: tb/tb_dual_list_writer.sv
// Bench for dual_list_writer: directed scenarios plus random traffic
// checked against a queue-based event model.
module tb_dual_list_writer;
   import dual_list_writer_pkg::*;

   localparam int DW  = 36;
   localparam int AW  = 6;
   localparam int CAP = 63;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] din1 = '0;
   logic          valid1 = 1'b0;
   logic [DW-1:0] din2 = '0;
   logic          valid2 = 1'b0;
   logic          wr_en1;
   logic [AW:0]   wr_addr1;
   logic [DW-1:0] wr_data1;
   logic          wr_en2;
   logic [AW:0]   wr_addr2;
   logic [DW-1:0] wr_data2;
   logic [AW-1:0] number1out;
   logic [AW-1:0] number2out;
   logic          rd_page;
   logic          done;
   logic [1:0]    overflow;

   int n_tests = 0;
   int n_fail  = 0;

   dual_list_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .din1       (din1),
      .valid1     (valid1),
      .din2       (din2),
      .valid2     (valid2),
      .wr_en1     (wr_en1),
      .wr_addr1   (wr_addr1),
      .wr_data1   (wr_data1),
      .wr_en2     (wr_en2),
      .wr_addr2   (wr_addr2),
      .wr_data2   (wr_data2),
      .number1out (number1out),
      .number2out (number2out),
      .rd_page    (rd_page),
      .done       (done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: lists of entries accepted in the open event.
   logic [DW-1:0] q1[$];
   logic [DW-1:0] q2[$];
   bit            m_filling;
   bit            m_page;
   bit            e_wen1, e_wen2, e_done, e_rdpage;
   logic [AW:0]   e_waddr1, e_waddr2;
   logic [DW-1:0] e_wdata1, e_wdata2;
   int            e_num1, e_num2;
   logic [1:0]    e_ovf;
   int            done_cnt;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      m_filling = 0;
      m_page    = 0;
      e_wen1 = 0; e_wen2 = 0; e_done = 0; e_rdpage = 1;
      e_waddr1 = '0; e_waddr2 = '0; e_wdata1 = '0; e_wdata2 = '0;
      e_num1 = 0; e_num2 = 0; e_ovf = 2'b00;
   endtask

   task automatic check_outputs();
      chk("done", done, e_done);
      chk("wr_en1", wr_en1, e_wen1);
      chk("wr_en2", wr_en2, e_wen2);
      if (e_wen1) begin
         chk("wr_addr1", wr_addr1, e_waddr1);
         chk("wr_data1", wr_data1, e_wdata1);
      end
      if (e_wen2) begin
         chk("wr_addr2", wr_addr2, e_waddr2);
         chk("wr_data2", wr_data2, e_wdata2);
      end
      chk("number1out", number1out, e_num1);
      chk("number2out", number2out, e_num2);
      chk("rd_page", rd_page, e_rdpage);
      chk("overflow", overflow, e_ovf);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1; start = 0; valid1 = 0; valid2 = 0;
      model_reset();
      #1;
      check_outputs();
      chk("rst_waddr1", wr_addr1, 0);
      chk("rst_wdata2", wr_data2, 0);
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   task automatic step(input bit s, input bit v1, input logic [DW-1:0] d1,
                       input bit v2, input logic [DW-1:0] d2);
      @(negedge clk);
      start = s; valid1 = v1; din1 = d1; valid2 = v2; din2 = d2;
      e_done = 0; e_wen1 = 0; e_wen2 = 0;
      if (s) begin
         if (m_filling) begin
            e_done   = 1;
            e_num1   = q1.size();
            e_num2   = q2.size();
            e_rdpage = m_page;
            m_page   = ~m_page;
         end
         m_filling = 1;
         q1.delete();
         q2.delete();
         e_ovf = 2'b00;
      end
      if (m_filling && v1) begin
         if (q1.size() < CAP) begin
            e_wen1   = 1;
            e_waddr1 = {m_page, 6'(q1.size())};
            e_wdata1 = d1;
            q1.push_back(d1);
         end else e_ovf[0] = 1'b1;
      end
      if (m_filling && v2) begin
         if (q2.size() < CAP) begin
            e_wen2   = 1;
            e_waddr2 = {m_page, 6'(q2.size())};
            e_wdata2 = d2;
            q2.push_back(d2);
         end else e_ovf[1] = 1'b1;
      end
      @(posedge clk);
      #1;
      check_outputs();
      if (done) done_cnt++;
   endtask

   function automatic logic [DW-1:0] rnd();
      return DW'({$urandom(), $urandom()});
   endfunction

   initial begin
      done_cnt = 0;
      model_reset();
      #2;
      do_reset();

      // 1: beats while idle are ignored
      for (int i = 0; i < 3; i++) step(0, 1, rnd(), 0, '0);
      chk("idle_num1", number1out, 0);

      // 2: basic event
      step(1, 0, '0, 0, '0);
      for (int i = 0; i < 5; i++) step(0, 1, rnd(), i < 2, rnd());
      step(1, 0, '0, 0, '0);
      chk("t2_num1", number1out, 5);
      chk("t2_num2", number2out, 2);
      chk("t2_rdpage", rd_page, 0);
      chk("t2_done", done, 1);

      // 3: saturation at 63 entries
      step(1, 0, '0, 0, '0);
      for (int i = 0; i < 70; i++) step(0, 1, rnd(), 0, '0);
      chk("t3_ovf", overflow, 2'b01);
      step(1, 0, '0, 0, '0);
      chk("t3_num1", number1out, 63);
      chk("t3_ovf_clr", overflow, 2'b00);

      // 4: beat coincident with start opens the new event
      step(0, 1, rnd(), 0, '0);
      step(1, 1, 36'hA5, 0, '0);
      chk("t4_num1", number1out, 1);
      chk("t4_wdata1", wr_data1, 36'hA5);
      step(1, 0, '0, 0, '0);
      chk("t4_next_num1", number1out, 1);

      // 5: back-to-back boundaries
      done_cnt = 0;
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);
      chk("t5_dones", done_cnt, 3);

      // 6: reset mid-fill, then restart without a done pulse
      for (int i = 0; i < 4; i++) step(0, 1, rnd(), 1, rnd());
      do_reset();
      step(1, 1, rnd(), 0, '0);
      chk("t6_done", done, 0);
      chk("t6_page", wr_addr1[AW], 0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 1999) == 0) do_reset();
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75, rnd(),
              $urandom_range(0, 99) < 60, rnd());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
